// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one rs232c transmitter among NUM_REQ byte sources.
// Optional TX_ARB_LOCK_EN: req_lock keeps the grant for atomic multi-byte messages.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_lock,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_data_en,
  input  logic                   tx_busy,
  output logic                   arb_busy,
  output logic                   timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_OH = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [PW-1:0]      ptr_r, ptr_s;
  logic [7:0]         cnt_r, cnt_s;
  logic [NUM_REQ-1:0] grant_r, grant_s;
  logic [NUM_REQ-1:0] req_ready_r, req_ready_s;
  logic [7:0]         tx_data_r, tx_data_s;
  logic               tx_data_en_r, tx_data_en_s;
  logic               arb_busy_r;
  logic               timeout_err_r, timeout_err_s;

  logic [NUM_REQ-1:0] eligible_s;
  logic               win_found_s;
  logic [PW-1:0]      win_idx_s;
  logic [PW-1:0]      idx_pw_s;
  int                 idx_v;

`ifdef TX_ARB_LOCK_EN
  logic               lock_r, lock_s;
  logic [PW-1:0]      lock_owner_r, lock_owner_s;

  // While locked only the owner may compete.
  always_comb begin
    if (lock_r) begin
      eligible_s = req_valid & (ONE_OH << lock_owner_r);
    end else begin
      eligible_s = req_valid;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = ^req_lock;

  // Without locking every valid requester competes.
  always_comb begin
    eligible_s = req_valid;
  end
`endif

  // First eligible requester after the round-robin pointer wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx_v       = 0;
    idx_pw_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v = int'(ptr_r) + k;
      if (idx_v >= NUM_REQ) begin
        idx_v = idx_v - NUM_REQ;
      end else begin
        idx_v = idx_v;
      end
      idx_pw_s = PW'(idx_v);
      if (!win_found_s && eligible_s[idx_pw_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_pw_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic of the transfer FSM.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    cnt_s         = cnt_r;
    grant_s       = grant_r;
    tx_data_s     = tx_data_r;
    tx_data_en_s  = 1'b0;
    req_ready_s   = '0;
    timeout_err_s = 1'b0;
`ifdef TX_ARB_LOCK_EN
    lock_s        = lock_r;
    lock_owner_s  = lock_owner_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!tx_busy && win_found_s) begin
          tx_data_s    = req_data[int'(win_idx_s)*8 +: 8];
          grant_s      = ONE_OH << win_idx_s;
          req_ready_s  = ONE_OH << win_idx_s;
          tx_data_en_s = 1'b1;
          ptr_s        = win_idx_s;
          cnt_s        = 8'd0;
          state_s      = ST_WAIT_START;
`ifdef TX_ARB_LOCK_EN
          lock_s       = req_lock[win_idx_s];
          lock_owner_s = win_idx_s;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_START: begin
        if (tx_busy) begin
          cnt_s   = 8'd0;
          state_s = ST_WAIT_DONE;
        end else if (cnt_r == 8'(START_TIMEOUT - 1)) begin
          // UART never started: drop the byte, its ready was already given.
          timeout_err_s = 1'b1;
          grant_s       = '0;
          cnt_s         = 8'd0;
          state_s       = ST_IDLE;
`ifdef TX_ARB_LOCK_EN
          lock_s        = 1'b0;
`endif
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          grant_s = '0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        grant_s = '0;
        cnt_s   = 8'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; pointer resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r       <= ST_IDLE;
      ptr_r         <= PW'(NUM_REQ - 1);
      cnt_r         <= 8'd0;
      grant_r       <= '0;
      req_ready_r   <= '0;
      tx_data_r     <= 8'd0;
      tx_data_en_r  <= 1'b0;
      arb_busy_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      cnt_r         <= cnt_s;
      grant_r       <= grant_s;
      req_ready_r   <= req_ready_s;
      tx_data_r     <= tx_data_s;
      tx_data_en_r  <= tx_data_en_s;
      arb_busy_r    <= (state_s != ST_IDLE);
      timeout_err_r <= timeout_err_s;
    end
  end

`ifdef TX_ARB_LOCK_EN
  // Lock flag and its owner.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lock_r       <= 1'b0;
      lock_owner_r <= '0;
    end else begin
      lock_r       <= lock_s;
      lock_owner_r <= lock_owner_s;
    end
  end
`endif

  assign grant       = grant_r;
  assign req_ready   = req_ready_r;
  assign tx_data     = tx_data_r;
  assign tx_data_en  = tx_data_en_r;
  assign arb_busy    = arb_busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple rs232c busy model and two byte sources.
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 10;

  logic        clk;
  logic        rstb;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_lock;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_data_en;
  logic        tx_busy;
  logic        arb_busy;
  logic        timeout_err;

  uart_tx_arbiter #(.NUM_REQ(2), .START_TIMEOUT(8)) dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .grant(grant),
    .tx_data(tx_data), .tx_data_en(tx_data_en), .tx_busy(tx_busy),
    .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       mdl_on, mdl_busy, mdl_pend, force_busy;
  int         mdl_cnt;
  logic [7:0] rq_bytes [2][6];
  logic       rq_lk    [2][6];
  int         rq_cnt [2];
  int         rq_idx [2];
  logic [7:0] rx_q [$];
  logic [1:0] gnt_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model and requesters update on negedge, then sample after posedge.
  task automatic tick();
    @(negedge clk);
    if (mdl_pend) begin
      mdl_busy = 1'b1; mdl_cnt = BUSY_LEN; mdl_pend = 1'b0;
    end else if (mdl_busy) begin
      if (mdl_cnt <= 1) mdl_busy = 1'b0;
      else mdl_cnt--;
    end
    if (tx_data_en) begin
      rx_q.push_back(tx_data);
      gnt_q.push_back(grant);
      if (mdl_on) mdl_pend = 1'b1;
    end
    tx_busy = mdl_busy | force_busy;
    for (int i = 0; i < 2; i++) begin
      if (req_ready[i]) rq_idx[i]++;
      req_valid[i]      = (rq_idx[i] < rq_cnt[i]);
      req_data[8*i +: 8] = req_valid[i] ? rq_bytes[i][rq_idx[i]] : 8'h00;
      req_lock[i]       = req_valid[i] ? rq_lk[i][rq_idx[i]] : 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_env();
    mdl_busy = 1'b0; mdl_pend = 1'b0; mdl_cnt = 0; mdl_on = 1'b1; force_busy = 1'b0;
    tx_busy = 1'b0; req_valid = 2'b00; req_data = 16'h0000; req_lock = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rq_cnt[i] = 0; rq_idx[i] = 0;
      for (int j = 0; j < 6; j++) begin
        rq_bytes[i][j] = 8'h00; rq_lk[i][j] = 1'b0;
      end
    end
    rx_q.delete();
    gnt_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    clear_env();
    @(negedge clk);
    rstb = 1'b1;
  endtask

  // Run until n bytes were sent and the arbiter is idle, bounded by lim cycles.
  task automatic run_until(input int nbytes, input int lim, input string tag);
    int n;
    n = 0;
    while (!(rx_q.size() >= nbytes && !arb_busy && !tx_busy) && n < lim) begin
      tick();
      n++;
    end
    chk({tag, "_bound"}, 32'(n < lim), 32'd1);
  endtask

  int n, en_x, rdy_x, tmo_at;
  logic seen;

  initial begin
    rstb = 1'b0;
    clear_env();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({grant, req_ready, tx_data, tx_data_en, arb_busy, timeout_err}), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    tick();
    chk("idle_no_req", 32'({grant, arb_busy}), 32'd0);

    // Single byte from requester 0.
    rq_bytes[0][0] = 8'h41; rq_cnt[0] = 1;
    tick();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_data", 32'(tx_data), 32'h41);
    chk("single_en", 32'(tx_data_en), 32'd1);
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_arb_busy", 32'(arb_busy), 32'd1);
    n = 0; en_x = 0; rdy_x = 0;
    do begin
      tick();
      n++;
      if (tx_data_en) en_x++;
      if (req_ready != 2'b00) rdy_x++;
    end while (arb_busy && n < 40);
    chk("single_idle_cycle", 32'(n), 32'd12);
    chk("single_extra_en", 32'(en_x), 32'd0);
    chk("single_extra_ready", 32'(rdy_x), 32'd0);
    chk("single_rx_count", 32'(rx_q.size()), 32'd1);
    chk("single_rx0", 32'(rx_q[0]), 32'h41);
    chk("single_tx_hold", 32'(tx_data), 32'h41);

    // Contention from reset: strict rotation 0,1,0,1.
    do_reset();
    rq_bytes[0][0] = 8'h30; rq_bytes[0][1] = 8'h31; rq_cnt[0] = 2;
    rq_bytes[1][0] = 8'h61; rq_bytes[1][1] = 8'h62; rq_cnt[1] = 2;
    run_until(4, 200, "contention");
    chk("cont_rx_count", 32'(rx_q.size()), 32'd4);
    chk("cont_rx0", 32'(rx_q[0]), 32'h30);
    chk("cont_rx1", 32'(rx_q[1]), 32'h61);
    chk("cont_rx2", 32'(rx_q[2]), 32'h31);
    chk("cont_rx3", 32'(rx_q[3]), 32'h62);
    chk("cont_gnt", 32'({gnt_q[0], gnt_q[1], gnt_q[2], gnt_q[3]}), 32'b01100110);

    // Deferred start while the UART is busy.
    rq_idx[0] = 0; rq_cnt[0] = 0;
    rq_idx[1] = 0; rq_cnt[1] = 1; rq_bytes[1][0] = 8'h55;
    force_busy = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (grant != 2'b00 || req_ready != 2'b00 || tx_data_en || arb_busy) seen = 1'b1;
    end
    chk("defer_no_grant", 32'(seen), 32'd0);
    force_busy = 1'b0;
    tick();
    chk("defer_grant", 32'(grant), 32'h2);
    chk("defer_ready", 32'(req_ready), 32'h2);
    chk("defer_data", 32'(tx_data), 32'h55);
    run_until(5, 60, "defer");
    chk("defer_rx", 32'(rx_q[rx_q.size()-1]), 32'h55);

    // Start timeout: UART never raises busy for requester 0's byte.
    rx_q.delete(); gnt_q.delete();
    mdl_on = 1'b0;
    rq_idx[0] = 0; rq_cnt[0] = 1; rq_bytes[0][0] = 8'h77;
    rq_idx[1] = 0; rq_cnt[1] = 1; rq_bytes[1][0] = 8'h88;
    tick();
    chk("tmo_first_grant", 32'({grant, tx_data, tx_data_en}), 32'({2'b01, 8'h77, 1'b1}));
    tmo_at = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (timeout_err && tmo_at == 0) tmo_at = k;
    end
    chk("tmo_cycle", 32'(tmo_at), 32'd8);
    chk("tmo_grant_clear", 32'({grant, arb_busy}), 32'd0);
    mdl_on = 1'b1;
    tick();
    chk("tmo_pulse_width", 32'(timeout_err), 32'd0);
    chk("tmo_next_served", 32'({grant, tx_data, tx_data_en}), 32'({2'b10, 8'h88, 1'b1}));
    run_until(2, 60, "tmo");

    // Multi-byte message from requester 1 with lock bits 1,1,0.
    do_reset();
    rq_bytes[0][0] = 8'h10; rq_bytes[0][1] = 8'h11; rq_cnt[0] = 2;
    rq_bytes[1][0] = 8'hA1; rq_bytes[1][1] = 8'hA2; rq_bytes[1][2] = 8'hA3; rq_cnt[1] = 3;
    rq_lk[1][0] = 1'b1; rq_lk[1][1] = 1'b1; rq_lk[1][2] = 1'b0;
    run_until(5, 300, "lock");
    chk("lock_rx_count", 32'(rx_q.size()), 32'd5);
`ifdef TX_ARB_LOCK_EN
    chk("lock_seq_a", 32'({rx_q[0], rx_q[1], rx_q[2], rx_q[3]}), 32'h10A1A2A3);
    chk("lock_seq_b", 32'(rx_q[4]), 32'h11);
`else
    chk("lock_seq_a", 32'({rx_q[0], rx_q[1], rx_q[2], rx_q[3]}), 32'h10A111A2);
    chk("lock_seq_b", 32'(rx_q[4]), 32'hA3);
`endif

    // Reset asserted while the UART is busy with a byte.
    rx_q.delete(); gnt_q.delete();
    rq_idx[0] = 0; rq_cnt[0] = 1; rq_bytes[0][0] = 8'h99;
    rq_idx[1] = 0; rq_cnt[1] = 0;
    tick();
    chk("rst_pre_grant", 32'(grant), 32'h1);
    repeat (4) tick();
    chk("rst_pre_busy", 32'({arb_busy, tx_busy}), 32'b11);
    #2;
    rstb = 1'b0;
    #1;
    chk("rst_async", 32'({grant, req_ready, tx_data_en, arb_busy}), 32'd0);
    clear_env();
    rq_bytes[0][0] = 8'h9A; rq_cnt[0] = 1;
    rq_bytes[1][0] = 8'h66; rq_cnt[1] = 1;
    @(negedge clk);
    rstb = 1'b1;
    tick();
    chk("rst_first_winner", 32'({grant, tx_data}), 32'({2'b01, 8'h9A}));
    run_until(2, 100, "rst_after");
    chk("rst_after_seq", 32'({rx_q[0], rx_q[1]}), 32'h9A66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
